// File: rtl/mc_ctrl_if.sv
// Memory handshake between the multicycle controller (master) and the memory system (slave).
// mem_req rises with a request and stays high until the slave answers with a one-cycle mem_ready.
interface mc_ctrl_if;
    logic mem_req;
    logic mem_write;
    logic mem_ready;

    modport master (output mem_req, output mem_write, input mem_ready);
    modport slave  (input mem_req, input mem_write, output mem_ready);
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// bus-timeout and illegal-instruction traps and a retired-instruction counter.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      instr,
    input  logic             alu_eq,
    mc_ctrl_if.master        mem,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [2:0]       next_pc_op,
    output logic [1:0]       reg_addr_op,
    output logic [2:0]       reg_data_op,
    output logic [3:0]       alu_op,
    output logic             a1_op,
    output logic [2:0]       alu_b_op,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        C_ADD, C_SUB, C_SLT, C_SLL, C_SRAV, C_JR, C_ORI,
        C_LUI, C_LW, C_LH, C_SW, C_BEQ, C_JAL
    } cls_e;

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

    state_e        state_q;
    cls_e          cls_q;
    cls_e          dec_cls;
    logic          dec_ok;
    logic [TW-1:0] wait_cnt;
    logic [3:0]    d_alu;
    logic [2:0]    d_b;
    logic          d_a1;
    logic [1:0]    d_addr;
    logic [2:0]    d_data;
    logic          unused_instr;

    assign unused_instr = ^instr[25:6];
    assign state        = state_q;

    always_comb begin
        dec_ok  = 1'b1;
        dec_cls = C_ADD;
        case (instr[31:26])
            6'b000000: begin
                case (instr[5:0])
                    6'b100000: dec_cls = C_ADD;
                    6'b100010: dec_cls = C_SUB;
                    6'b101010: dec_cls = C_SLT;
                    6'b000000: dec_cls = C_SLL;
                    6'b000111: dec_cls = C_SRAV;
                    6'b001000: dec_cls = C_JR;
                    default:   dec_ok  = 1'b0;
                endcase
            end
            6'b001101: dec_cls = C_ORI;
            6'b001111: dec_cls = C_LUI;
            6'b100011: dec_cls = C_LW;
            6'b100001: dec_cls = C_LH;
            6'b101011: dec_cls = C_SW;
            6'b000100: dec_cls = C_BEQ;
            6'b000011: dec_cls = C_JAL;
            default:   dec_ok  = 1'b0;
        endcase
    end

    // Datapath selects per class; latched on DECODE->EXEC and held until the next decode.
    always_comb begin
        d_alu  = 4'd0;
        d_b    = 3'd0;
        d_a1   = 1'b0;
        d_addr = 2'd0;
        d_data = 3'd0;
        case (dec_cls)
            C_SUB:  d_alu = 4'd1;
            C_SLT:  begin d_alu = 4'd3; d_data = 3'd5; end
            C_SLL:  begin d_alu = 4'd4; d_a1 = 1'b1; d_b = 3'd3; end
            C_SRAV: d_alu = 4'd5;
            C_ORI:  begin d_alu = 4'd2; d_b = 3'd2; d_addr = 2'd1; end
            C_LUI:  begin d_b = 3'd2; d_addr = 2'd1; d_data = 3'd2; end
            C_LW:   begin d_b = 3'd1; d_addr = 2'd1; d_data = 3'd1; end
            C_LH:   begin d_b = 3'd1; d_addr = 2'd1; d_data = 3'd4; end
            C_SW:   d_b = 3'd1;
            C_BEQ:  d_alu = 4'd1;
            C_JAL:  begin d_addr = 2'd2; d_data = 3'd3; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cls_q         <= C_ADD;
            wait_cnt      <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_write <= 1'b0;
            trap          <= 1'b0;
            trap_cause    <= 2'd0;
            retired       <= '0;
            alu_op        <= 4'd0;
            alu_b_op      <= 3'd0;
            a1_op         <= 1'b0;
            reg_addr_op   <= 2'd0;
            reg_data_op   <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q     <= S_FETCH;
                    mem.mem_req <= 1'b1;
                    wait_cnt    <= '0;
                end
                S_FETCH, S_MEM: begin
                    // A completion in the last allowed cycle beats the timeout.
                    if (mem.mem_ready) begin
                        wait_cnt      <= '0;
                        mem.mem_write <= 1'b0;
                        if (state_q == S_FETCH) begin
                            state_q     <= S_DECODE;
                            mem.mem_req <= 1'b0;
                        end else if (cls_q == C_SW) begin
                            state_q <= S_FETCH;
                            retired <= retired + CNT_W'(1);
                        end else begin
                            state_q     <= S_WB;
                            mem.mem_req <= 1'b0;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_q       <= S_TRAP;
                        mem.mem_req   <= 1'b0;
                        mem.mem_write <= 1'b0;
                        trap          <= 1'b1;
                        trap_cause    <= 2'd2;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_DECODE: begin
                    if (dec_ok) begin
                        state_q     <= S_EXEC;
                        cls_q       <= dec_cls;
                        alu_op      <= d_alu;
                        alu_b_op    <= d_b;
                        a1_op       <= d_a1;
                        reg_addr_op <= d_addr;
                        reg_data_op <= d_data;
                    end else begin
                        state_q    <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'd1;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    case (cls_q)
                        C_LW, C_LH, C_SW: begin
                            state_q       <= S_MEM;
                            mem.mem_req   <= 1'b1;
                            mem.mem_write <= (cls_q == C_SW);
                        end
                        C_BEQ, C_JAL, C_JR: begin
                            state_q     <= S_FETCH;
                            mem.mem_req <= 1'b1;
                            retired     <= retired + CNT_W'(1);
                        end
                        default: state_q <= S_WB;
                    endcase
                end
                S_WB: begin
                    state_q     <= S_FETCH;
                    mem.mem_req <= 1'b1;
                    wait_cnt    <= '0;
                    retired     <= retired + CNT_W'(1);
                end
                S_TRAP: state_q <= S_TRAP;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes qualify the edge that ends the current cycle, so they follow mem_ready/alu_eq directly.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        next_pc_op = 3'd0;
        case (state_q)
            S_FETCH: begin
                ir_write = mem.mem_ready;
                pc_write = mem.mem_ready;
            end
            S_EXEC: begin
                case (cls_q)
                    C_BEQ: begin next_pc_op = 3'd1; pc_write = alu_eq; end
                    C_JAL: begin next_pc_op = 3'd2; pc_write = 1'b1; reg_write = 1'b1; end
                    C_JR:  begin next_pc_op = 3'd3; pc_write = 1'b1; end
                    default: ;
                endcase
            end
            S_WB: reg_write = 1'b1;
            default: ;
        endcase
    end
endmodule
